// File: rtl/servo_pwm_array_pkg.sv
// Default 100 MHz / SG-90 timing constants and command clamping for the servo PWM array.
package servo_pkg;

    localparam int DEF_PERIOD_CLKS = 2_000_000;
    localparam int DEF_MIN_CLKS    = 100_000;
    localparam int DEF_SPAN_CLKS   = 100_000;
    localparam int DEF_STEP_CLKS   = 500;
    localparam int DEF_INIT_POS    = 50_000;

    // Out-of-range targets saturate at full travel rather than wrapping.
    function automatic int clamp_pos(input int pos, input int span);
        return (pos > span) ? span : pos;
    endfunction

endpackage

// File: rtl/servo_pwm_array_if.sv
// Target-command bus from the position controller into the servo array.
interface servo_cmd_if #(
    parameter int CH_W  = 2,
    parameter int POS_W = 17
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CH_W-1:0]  cmd_ch;
    logic [POS_W-1:0] cmd_pos;
    logic             cmd_err;

    modport master (output cmd_valid, cmd_ch, cmd_pos, input cmd_ready, cmd_err);
    modport slave  (input cmd_valid, cmd_ch, cmd_pos, output cmd_ready, cmd_err);
endinterface

// File: rtl/servo_pwm_array_channel.sv
// One servo channel: target/current/latched width, per-frame slew step, PWM compare, at-target flag.
module servo_channel #(
    parameter int CNT_W     = 21,
    parameter int POS_W     = 17,
    parameter int MIN_CLKS  = 100_000,
    parameter int SPAN_CLKS = 100_000,
    parameter int STEP_CLKS = 500,
    parameter int INIT_POS  = 50_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic             wrap,
    input  logic             load,
    input  logic [POS_W-1:0] pos,
    output logic             pwm,
    output logic             led
);

    localparam int CMP_W    = (POS_W + 1 > CNT_W) ? POS_W + 1 : CNT_W;
    localparam int STEP_EFF = (STEP_CLKS > SPAN_CLKS) ? SPAN_CLKS : STEP_CLKS;
    localparam int INIT_EFF = (INIT_POS > SPAN_CLKS) ? SPAN_CLKS : INIT_POS;
    localparam logic [POS_W:0]   STEP_V = (POS_W + 1)'(STEP_EFF);
    localparam logic [POS_W-1:0] INIT_V = POS_W'(INIT_EFF);
    localparam logic [CMP_W-1:0] MIN_V  = CMP_W'(MIN_CLKS);

    logic [POS_W-1:0] tgt, cur, wid, cur_nxt;
    logic [POS_W:0]   diff;
    logic             up;

    // Step never overshoots: a full step is only taken when the gap exceeds it.
    always_comb begin
        up      = (tgt >= cur);
        diff    = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        cur_nxt = tgt;
        if (diff > STEP_V)
            cur_nxt = up ? (cur + STEP_V[POS_W-1:0]) : (cur - STEP_V[POS_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt <= INIT_V;
            cur <= INIT_V;
            wid <= INIT_V;
            pwm <= 1'b0;
            led <= 1'b1;
        end else begin
            if (load)
                tgt <= pos;
            // wid only moves at the wrap so a running pulse is never cut or stretched.
            if (wrap) begin
                cur <= cur_nxt;
                wid <= cur_nxt;
            end
            pwm <= en & (CMP_W'(cnt) < (MIN_V + CMP_W'(wid)));
            led <= (cur == tgt);
        end
    end

endmodule

// File: rtl/servo_pwm_array.sv
// Multi-channel hobby-servo PWM generator: shared frame counter, command decode, slew-limited channels.
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int PERIOD_CLKS = DEF_PERIOD_CLKS,
    parameter int MIN_CLKS    = DEF_MIN_CLKS,
    parameter int SPAN_CLKS   = DEF_SPAN_CLKS,
    parameter int STEP_CLKS   = DEF_STEP_CLKS,
    parameter int INIT_POS    = DEF_INIT_POS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    servo_cmd_if.slave     cmd,
    output logic           frame_tick,
    output logic [NCH-1:0] JA,
    output logic [NCH-1:0] led
);

    localparam int CNT_W = $clog2(PERIOD_CLKS);
    localparam int POS_W = $clog2(SPAN_CLKS + 1);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD_CLKS - 1);
    localparam logic [CH_W:0]    NCH_V = (CH_W + 1)'(NCH);

    logic [CNT_W-1:0] cnt;
    logic             wrap, accept, ch_bad;
    logic [POS_W-1:0] pos_c;
    logic [NCH-1:0]   load;

    assign cmd.cmd_ready = ~rst;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign ch_bad        = ({1'b0, cmd.cmd_ch} >= NCH_V);
    assign wrap          = en & (cnt == LAST);
    assign pos_c         = POS_W'(clamp_pos(int'(cmd.cmd_pos), SPAN_CLKS));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            frame_tick  <= 1'b0;
            cmd.cmd_err <= 1'b0;
        end else begin
            if (!en || wrap)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            frame_tick  <= wrap;
            cmd.cmd_err <= accept & ch_bad;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign load[c] = accept & ({1'b0, cmd.cmd_ch} == (CH_W + 1)'(c));

        servo_channel #(
            .CNT_W    (CNT_W),
            .POS_W    (POS_W),
            .MIN_CLKS (MIN_CLKS),
            .SPAN_CLKS(SPAN_CLKS),
            .STEP_CLKS(STEP_CLKS),
            .INIT_POS (INIT_POS)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .cnt (cnt),
            .wrap(wrap),
            .load(load[c]),
            .pos (pos_c),
            .pwm (JA[c]),
            .led (led[c])
        );
    end

endmodule
